blob_bbox_scanner: RTL and testbench

BLOB_BBOX_SCANNER -- requirements
Module: blob_bbox_scanner

---
 rtl/blob_bbox_scanner.sv | 189 ++++++++++++++++++
 tb/tb_blob_bbox_scanner.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/blob_bbox_scanner.sv
// Raster-scans a 1-bit bitmap buffer and reports the bounding box and count of white pixels.
// Optional macro BLOB_BBOX_SUMS_EN adds sum_x/sum_y outputs for downstream centroid computation.
module blob_bbox_scanner #(
   parameter int  IMG_WIDTH  = 640,
   parameter int  IMG_HEIGHT = 480,
   localparam int P  = IMG_WIDTH * IMG_HEIGHT,
   localparam int AW = $clog2(P),
   localparam int XW = $clog2(IMG_WIDTH),
   localparam int YW = $clog2(IMG_HEIGHT),
   localparam int CW = $clog2(P + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   output logic [AW-1:0] rd_addr,
   input  logic          rd_data,
   output logic          busy,
   output logic          res_valid,
   input  logic          res_ready,
   output logic          res_found,
   output logic [XW-1:0] min_x,
   output logic [XW-1:0] max_x,
   output logic [YW-1:0] min_y,
   output logic [YW-1:0] max_y,
`ifdef BLOB_BBOX_SUMS_EN
   output logic [XW+CW-1:0] sum_x,
   output logic [YW+CW-1:0] sum_y,
`endif
   output logic [CW-1:0] pix_count
);

   typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

   localparam logic [AW-1:0] LAST_ADDR = AW'(P - 1);
   localparam logic [XW-1:0] LAST_X    = XW'(IMG_WIDTH - 1);
   localparam logic [YW-1:0] LAST_Y    = YW'(IMG_HEIGHT - 1);

   state_t          state_q, state_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [XW-1:0]   x_q, x_d;
   logic [YW-1:0]   y_q, y_d;
   logic [XW-1:0]   pipe_x_q, pipe_x_d;
   logic [YW-1:0]   pipe_y_q, pipe_y_d;
   logic            pipe_v_q, pipe_v_d;
   logic            found_q, found_d;
   logic [XW-1:0]   min_x_q, min_x_d, max_x_q, max_x_d;
   logic [YW-1:0]   min_y_q, min_y_d, max_y_q, max_y_d;
   logic [CW-1:0]   cnt_q, cnt_d;
`ifdef BLOB_BBOX_SUMS_EN
   logic [XW+CW-1:0] sum_x_q, sum_x_d;
   logic [YW+CW-1:0] sum_y_q, sum_y_d;
`endif

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      x_d      = x_q;
      y_d      = y_q;
      pipe_x_d = x_q;
      pipe_y_d = y_q;
      pipe_v_d = (state_q == SCAN);
      found_d  = found_q;
      min_x_d  = min_x_q;
      max_x_d  = max_x_q;
      min_y_d  = min_y_q;
      max_y_d  = max_y_q;
      cnt_d    = cnt_q;
`ifdef BLOB_BBOX_SUMS_EN
      sum_x_d  = sum_x_q;
      sum_y_d  = sum_y_q;
`endif

      // rd_data belongs to the coordinate issued one cycle earlier, held in the pipe registers
      if (pipe_v_q && rd_data) begin
         found_d = 1'b1;
         cnt_d   = cnt_q + CW'(1);
         if (pipe_x_q < min_x_q) min_x_d = pipe_x_q;
         if (pipe_x_q > max_x_q) max_x_d = pipe_x_q;
         if (pipe_y_q < min_y_q) min_y_d = pipe_y_q;
         if (pipe_y_q > max_y_q) max_y_d = pipe_y_q;
`ifdef BLOB_BBOX_SUMS_EN
         sum_x_d = sum_x_q + (XW+CW)'(pipe_x_q);
         sum_y_d = sum_y_q + (YW+CW)'(pipe_y_q);
`endif
      end

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = SCAN;
               addr_d  = '0;
               x_d     = '0;
               y_d     = '0;
               found_d = 1'b0;
               cnt_d   = '0;
               min_x_d = LAST_X;
               min_y_d = LAST_Y;
               max_x_d = '0;
               max_y_d = '0;
`ifdef BLOB_BBOX_SUMS_EN
               sum_x_d = '0;
               sum_y_d = '0;
`endif
            end
         end
         SCAN: begin
            if (addr_q == LAST_ADDR) begin
               state_d = DRAIN;
               addr_d  = '0;
               x_d     = '0;
               y_d     = '0;
            end else begin
               addr_d = addr_q + AW'(1);
               if (x_q == LAST_X) begin
                  x_d = '0;
                  y_d = y_q + YW'(1);
               end else begin
                  x_d = x_q + XW'(1);
               end
            end
         end
         DRAIN: begin
            state_d = DONE;
         end
         DONE: begin
            if (res_ready) state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         x_q      <= '0;
         y_q      <= '0;
         pipe_x_q <= '0;
         pipe_y_q <= '0;
         pipe_v_q <= 1'b0;
         found_q  <= 1'b0;
         min_x_q  <= '0;
         max_x_q  <= '0;
         min_y_q  <= '0;
         max_y_q  <= '0;
         cnt_q    <= '0;
`ifdef BLOB_BBOX_SUMS_EN
         sum_x_q  <= '0;
         sum_y_q  <= '0;
`endif
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         x_q      <= x_d;
         y_q      <= y_d;
         pipe_x_q <= pipe_x_d;
         pipe_y_q <= pipe_y_d;
         pipe_v_q <= pipe_v_d;
         found_q  <= found_d;
         min_x_q  <= min_x_d;
         max_x_q  <= max_x_d;
         min_y_q  <= min_y_d;
         max_y_q  <= max_y_d;
         cnt_q    <= cnt_d;
`ifdef BLOB_BBOX_SUMS_EN
         sum_x_q  <= sum_x_d;
         sum_y_q  <= sum_y_d;
`endif
      end
   end

   assign rd_addr   = addr_q;
   assign busy      = (state_q == SCAN) || (state_q == DRAIN);
   assign res_valid = (state_q == DONE);
   assign res_found = found_q;
   // Minimums still hold their clear value on an empty frame, so mask them to read 0
   assign min_x     = found_q ? min_x_q : '0;
   assign min_y     = found_q ? min_y_q : '0;
   assign max_x     = max_x_q;
   assign max_y     = max_y_q;
   assign pix_count = cnt_q;
`ifdef BLOB_BBOX_SUMS_EN
   assign sum_x     = sum_x_q;
   assign sum_y     = sum_y_q;
`endif

endmodule

// File: tb/tb_blob_bbox_scanner.sv
// Self-checking bench for blob_bbox_scanner on an 8x4 frame: a frame-level reference model
// plus a per-cycle compare process, directed literal cases and randomized frames.
module tb_blob_bbox_scanner;

   localparam int W  = 8;
   localparam int H  = 4;
   localparam int P  = W * H;
   localparam int AW = $clog2(P);
   localparam int XW = $clog2(W);
   localparam int YW = $clog2(H);
   localparam int CW = $clog2(P + 1);

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          rd_data = 1'b0;
   logic          res_ready = 1'b0;
   logic [AW-1:0] rd_addr;
   logic          busy, res_valid, res_found;
   logic [XW-1:0] min_x, max_x;
   logic [YW-1:0] min_y, max_y;
   logic [CW-1:0] pix_count;
`ifdef BLOB_BBOX_SUMS_EN
   logic [XW+CW-1:0] sum_x;
   logic [YW+CW-1:0] sum_y;
`endif

   typedef struct {
      bit     found;
      int     minX, maxX, minY, maxY, count;
      longint sumX, sumY;
   } result_t;

   int      nChecks = 0;
   int      nFail = 0;
   int      cyc = 0;
   int      tStart = 0;
   int      tMain = 0;
   int      lat;
   int      k;
   bit      modelActive = 1'b0;
   bit      wasIdle;
   bit      expBusy, expValid;
   int      expAddr;
   bit      img [P];
   result_t expRes;

   blob_bbox_scanner #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .busy      (busy),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_found (res_found),
      .min_x     (min_x),
      .max_x     (max_x),
      .min_y     (min_y),
      .max_y     (max_y),
`ifdef BLOB_BBOX_SUMS_EN
      .sum_x     (sum_x),
      .sum_y     (sum_y),
`endif
      .pix_count (pix_count)
   );

   // Free-running clock
   always #5 clk = ~clk;

   // Cycle counter plus a synchronous-read bitmap buffer with one cycle of latency
   always @(posedge clk) begin
      cyc     <= cyc + 1;
      rd_data <= img[rd_addr];
   end

   task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
      nChecks++;
      if (got !== exp) begin
         nFail++;
         $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // Reference model: scan the whole frame as a 2-D picture and summarise it
   function automatic result_t modelFrame();
      result_t r;
      r.found = 1'b0;
      r.count = 0;
      r.minX = W; r.maxX = -1; r.minY = H; r.maxY = -1;
      r.sumX = 0; r.sumY = 0;
      for (int y = 0; y < H; y++) begin
         for (int x = 0; x < W; x++) begin
            if (img[y*W + x]) begin
               r.found = 1'b1;
               r.count++;
               r.sumX += x;
               r.sumY += y;
               if (x < r.minX) r.minX = x;
               if (x > r.maxX) r.maxX = x;
               if (y < r.minY) r.minY = y;
               if (y > r.maxY) r.maxY = y;
            end
         end
      end
      if (!r.found) begin
         r.minX = 0; r.maxX = 0; r.minY = 0; r.maxY = 0;
      end
      return r;
   endfunction

   // Compare process: every cycle, checks handshake/address timing and, while valid, the result
   always @(negedge clk) begin
      if (!rst_n) begin
         modelActive = 1'b0;
      end else begin
         wasIdle  = !modelActive;
         expBusy  = 1'b0;
         expValid = 1'b0;
         expAddr  = 0;
         if (modelActive) begin
            k        = cyc - tStart;
            expBusy  = (k >= 1) && (k <= P + 1);
            expValid = (k >= P + 2);
            expAddr  = ((k >= 1) && (k <= P)) ? k - 1 : 0;
         end
         checkOutput("busy", busy, expBusy);
         checkOutput("res_valid", res_valid, expValid);
         checkOutput("rd_addr", rd_addr, expAddr);
         if (expValid) begin
            checkOutput("res_found", res_found, expRes.found);
            checkOutput("min_x", min_x, expRes.minX);
            checkOutput("max_x", max_x, expRes.maxX);
            checkOutput("min_y", min_y, expRes.minY);
            checkOutput("max_y", max_y, expRes.maxY);
            checkOutput("pix_count", pix_count, expRes.count);
`ifdef BLOB_BBOX_SUMS_EN
            checkOutput("sum_x", sum_x, expRes.sumX);
            checkOutput("sum_y", sum_y, expRes.sumY);
`endif
            if (res_ready) modelActive = 1'b0;
         end
         if (wasIdle && start) begin
            modelActive = 1'b1;
            tStart      = cyc;
            expRes      = modelFrame();
         end
      end
   end

   // Pulse start for one cycle; called just after a rising edge
   task automatic applyStimulus();
      start = 1'b1;
      tMain = cyc;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic waitResult(output int latency);
      for (int i = 0; i < 200; i++) begin
         if (res_valid) break;
         @(posedge clk); #1;
      end
      if (!res_valid) checkOutput("res_valid_timeout", 0, 1);
      latency = cyc - tMain;
   endtask

   task automatic checkZero(input string tag);
      checkOutput({tag, "_busy"}, busy, 0);
      checkOutput({tag, "_res_valid"}, res_valid, 0);
      checkOutput({tag, "_rd_addr"}, rd_addr, 0);
      checkOutput({tag, "_res_found"}, res_found, 0);
      checkOutput({tag, "_box"}, {min_x, max_x, min_y, max_y}, 0);
      checkOutput({tag, "_pix_count"}, pix_count, 0);
`ifdef BLOB_BBOX_SUMS_EN
      checkOutput({tag, "_sums"}, {sum_x, sum_y}, 0);
`endif
   endtask

   task automatic clearImg();
      for (int i = 0; i < P; i++) img[i] = 1'b0;
   endtask

   task automatic randomImg(input int dens);
      for (int i = 0; i < P; i++) img[i] = ($urandom_range(0, 99) < dens);
   endtask

   initial begin
      @(posedge clk); #1;
      rst_n = 1'b0;
      res_ready = 1'b1;
      @(posedge clk); #1;
      checkZero("reset");
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Single white pixel at (3,2)
      clearImg();
      img[2*W + 3] = 1'b1;
      applyStimulus();
      waitResult(lat);
      checkOutput("latency_single", lat, 34);
      checkOutput("single_box", {min_x, max_x, min_y, max_y}, {3'd3, 3'd3, 2'd2, 2'd2});
      checkOutput("single_count", pix_count, 1);
      checkOutput("single_found", res_found, 1);
      @(posedge clk); #1;

      // Two pixels at opposite corners of the box
      clearImg();
      img[0*W + 1] = 1'b1;
      img[3*W + 6] = 1'b1;
      applyStimulus();
      waitResult(lat);
      checkOutput("pair_box", {min_x, max_x, min_y, max_y}, {3'd1, 3'd6, 2'd0, 2'd3});
      checkOutput("pair_count", pix_count, 2);
`ifdef BLOB_BBOX_SUMS_EN
      checkOutput("pair_sum_x", sum_x, 7);
      checkOutput("pair_sum_y", sum_y, 3);
`endif
      @(posedge clk); #1;

      // Empty frame
      clearImg();
      applyStimulus();
      waitResult(lat);
      checkOutput("black_found", res_found, 0);
      checkOutput("black_box", {min_x, max_x, min_y, max_y}, 0);
      checkOutput("black_count", pix_count, 0);
      @(posedge clk); #1;

      // Full-white frame, count reaches P
      for (int i = 0; i < P; i++) img[i] = 1'b1;
      applyStimulus();
      waitResult(lat);
      checkOutput("white_box", {min_x, max_x, min_y, max_y}, {3'd0, 3'd7, 2'd0, 2'd3});
      checkOutput("white_count", pix_count, 32);
      @(posedge clk); #1;

      // Back-pressure with spurious starts in SCAN and DONE, then accept+start together
      randomImg(40);
      res_ready = 1'b0;
      applyStimulus();
      repeat (4) @(posedge clk);
      #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      waitResult(lat);
      checkOutput("latency_stall", lat, 34);
      for (int i = 0; i < 10; i++) begin
         start = (i == 3);
         @(posedge clk); #1;
      end
      start = 1'b0;
      res_ready = 1'b1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (40) @(posedge clk);
      #1;
      checkOutput("no_second_result", res_valid, 0);

      // Reset in the middle of a scan
      randomImg(50);
      applyStimulus();
      repeat (14) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      checkZero("midscan_reset");
      rst_n = 1'b1;
      repeat (40) @(posedge clk);
      #1;
      randomImg(30);
      applyStimulus();
      waitResult(lat);
      checkOutput("latency_after_reset", lat, 34);
      @(posedge clk); #1;

      // Reset while holding a result in DONE
      randomImg(60);
      res_ready = 1'b0;
      applyStimulus();
      waitResult(lat);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      checkZero("done_reset");
      rst_n = 1'b1;
      res_ready = 1'b1;
      repeat (40) @(posedge clk);
      #1;

      // Randomized frames with random back-pressure
      for (int f = 0; f < 12; f++) begin
         randomImg($urandom_range(0, 100));
         res_ready = 1'b0;
         applyStimulus();
         waitResult(lat);
         checkOutput("latency_random", lat, 34);
         repeat ($urandom_range(0, 4)) @(posedge clk);
         #1;
         res_ready = 1'b1;
         @(posedge clk); #1;
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #1;
      end

      repeat (5) @(posedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end

endmodule
